q_table_engine: RTL and testbench
=================================

// Module: q_table_engine
// PURPOSE
//  Inside-side command engine. Consumes 64-bit messages popped from the AXI in_fifo and executes
//  Q-table ops (write/read/update/argmax/clear) on a local N_STATES x N_ACTIONS signed table.
//  Pushes exactly one 64-bit response per command into the AXI out_fifo.
//  Sits directly between the FIFO bridge's inside ports (in pop side, out push side).
// PARAMETERS
//  W_MSG      64  message width (fixed layout below; must stay 64)
//  N_STATES   16  table rows; state idx legal range 0..N_STATES-1
//  N_ACTIONS  4   table cols; action idx legal range 0..N_ACTIONS-1
//  W_Q        16  signed Q-value width
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous, active-high reset
//  in_msg_rdy   in   1      top of in_fifo valid
//  in_msg       in   W_MSG  top of in_fifo
//  in_msg_ack   out  1      1-cycle pop pulse to in_fifo
//  out_msg_rdy  out  1      response valid, held until acked
//  out_msg      out  W_MSG  response word
//  out_msg_ack  in   1      out_fifo accepted response
//  busy         out  1      FSM not in IDLE
// BEHAVIOUR
//  Cmd layout: [63:60] op, [59:48] state, [47:40] action, [39:32] sh, [15:0] value (signed). Other bits ignored.
//  Rsp layout: [63:60] op echo, [59:48] state echo, [47:40] action (ARGMAX: best action), [32] err,
//   [15:0] value. All other bits are 0.
//  Ops:
//   - 1 WRITE: Q[s][a] <= v; rsp val = v.
//   - 2 READ: rsp val = Q[s][a].
//   - 3 UPDATE: d = (W_Q+1)-bit sext(v) - sext(Q); Q <= Q + (d >>> sh); rsp val = new Q.
//     Result always lies in [min(Q,v), max(Q,v)], so no saturation is needed.
//   - 4 ARGMAX: scan a = 0..N_ACTIONS-1 of row s, one entry per cycle, strict > compare;
//     ties resolve to the lowest index. rsp action = best, val = max.
//   - 5 CLEAR: zero every entry, one per cycle, in row-major order. rsp val = 0.
//   - 0 and 6..15: illegal. rsp err = 1, val = 0.
//  Error: err = 1, val = 0, table untouched, when any of these holds:
//   - state >= N_STATES (any op except CLEAR);
//   - action >= N_ACTIONS (WRITE/READ/UPDATE);
//   - UPDATE with sh > 15.
//  FSM: IDLE -> EXEC -> {SCAN | CLR} -> RESP -> IDLE.
//   - IDLE: when in_msg_rdy = 1, latch in_msg and go to EXEC. in_msg_ack = 1 for exactly the next cycle.
//   - EXEC: decode and check. Single-cycle ops write the table and form the rsp, then go to RESP.
//     ARGMAX goes to SCAN; CLEAR goes to CLR.
//   - SCAN: N_ACTIONS cycles. CLR: N_STATES*N_ACTIONS cycles. Each then goes to RESP.
//   - RESP: out_msg_rdy = 1 with out_msg stable. At the edge where out_msg_ack = 1, go to IDLE;
//     out_msg_rdy = 0 in the following cycle.
//  Latency (in_msg_rdy sampled in IDLE to out_msg_rdy high):
//   - 2 cycles for WRITE/READ/UPDATE/illegal;
//   - N_ACTIONS+2 cycles for ARGMAX;
//   - N_STATES*N_ACTIONS+2 cycles for CLEAR.
//  One command in flight only. in_msg is ignored outside IDLE. The next command is accepted at the
//   earliest on the first IDLE cycle after the response is acked.
//  Backpressure: out_msg_ack low indefinitely keeps the FSM in RESP with outputs frozen.
//  Reset: in_msg_ack = 0, out_msg_rdy = 0, out_msg = 0, busy = 0, FSM = IDLE.
//   Table contents are NOT reset. Reset mid-SCAN/CLR abandons the op (partial CLEAR is permitted)
//   and no response is emitted.
// STRUCTURE
//  q_engine_pkg holds:
//   - op enum and FSM state enum;
//   - cmd/rsp field offset constants;
//   - ERR_BIT = 32.
//  Sub-module q_update_alu: combinational (W_Q+1)-bit update, Q,v,sh -> newQ.
//  Table is a register array with combinational read.
// TESTING
//  1. After reset, WRITE s=3 a=1 v=0x0100:
//     in_msg_ack is a single pulse; out_msg_rdy rises 2 cycles after accept;
//     rsp op=1 s=3 a=1 err=0 val=0x0100.
//  2. READ s=3 a=1 -> val=0x0100.
//     UPDATE s=3 a=1 v=0x0200 sh=2 -> val=0x0140.
//     UPDATE v=0x8000 sh=0 on Q=0x7FFF -> val=0x8000.
//  3. WRITE row 3 with a0=0x0005, a1=0x0140, a2=0x0140, a3=0xFFFF, then ARGMAX s=3
//     -> a=1 val=0x0140, latency 6 cycles.
//  4. op=0xF -> err=1 val=0. READ s=16 -> err=1. UPDATE sh=16 -> err=1.
//     Each is followed by READ s=3 a=1, which returns an unchanged 0x0140.
//  5. CLEAR -> rsp after 66 cycles, busy high throughout; READ s=15 a=3 and READ s=3 a=1 both return 0.
//  6. Hold out_msg_ack=0 for 10 cycles with the next cmd queued: out_msg is stable and in_msg_ack stays low.
//     Then assert rst mid-ARGMAX: all outputs are 0 on the next cycle and no response is emitted.

Source files
------------

// File: rtl/q_engine_pkg.sv
// Shared opcodes, FSM states and message field layout for the Q-table command engine.
package q_engine_pkg;

    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,
        OP_WRITE  = 4'd1,
        OP_READ   = 4'd2,
        OP_UPDATE = 4'd3,
        OP_ARGMAX = 4'd4,
        OP_CLEAR  = 4'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SCAN,
        S_CLR,
        S_RESP
    } state_e;

    localparam int OP_LSB  = 60;
    localparam int OP_W    = 4;
    localparam int ST_LSB  = 48;
    localparam int ST_W    = 12;
    localparam int ACT_LSB = 40;
    localparam int ACT_W   = 8;
    localparam int SH_LSB  = 32;
    localparam int SH_W    = 8;
    localparam int VAL_LSB = 0;
    localparam int ERR_BIT = 32;
    localparam int MAX_SH  = 15;

endpackage

// File: rtl/q_update_alu.sv
// Combinational Q-learning step: new_q = q + ((v - q) >>> sh), evaluated one bit wider than W_Q.
module q_update_alu #(
    parameter int W_Q = 16
) (
    input  logic signed [W_Q-1:0] q,
    input  logic signed [W_Q-1:0] v,
    input  logic        [3:0]     sh,
    output logic signed [W_Q-1:0] new_q
);
    logic signed [W_Q:0] diff;
    logic signed [W_Q:0] step;
    logic signed [W_Q:0] sum;

    // The sum always lands between q and v, so dropping the top bit never wraps.
    always_comb begin
        diff  = $signed({v[W_Q-1], v}) - $signed({q[W_Q-1], q});
        step  = diff >>> sh;
        sum   = step + $signed({q[W_Q-1], q});
        new_q = sum[W_Q-1:0];
    end

endmodule

// File: rtl/q_table_engine.sv
// Command engine: pops one message, executes a Q-table op on a local register table,
// and pushes exactly one response, holding it until the out FIFO accepts it.
module q_table_engine
    import q_engine_pkg::*;
#(
    parameter int W_MSG     = 64,
    parameter int N_STATES  = 16,
    parameter int N_ACTIONS = 4,
    parameter int W_Q       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_msg_rdy,
    input  logic [W_MSG-1:0] in_msg,
    output logic             in_msg_ack,
    output logic             out_msg_rdy,
    output logic [W_MSG-1:0] out_msg,
    input  logic             out_msg_ack,
    output logic             busy
);
    localparam int N_ENT = N_STATES * N_ACTIONS;
    localparam int IDX_W = $clog2(N_ENT);

    state_e                state;
    logic [IDX_W-1:0]      idx;
    logic [OP_W-1:0]       op_r;
    logic [ST_W-1:0]       st_r;
    logic [ACT_W-1:0]      act_r;
    logic [SH_W-1:0]       sh_r;
    logic signed [W_Q-1:0] val_r;
    logic signed [W_Q-1:0] best_val;
    logic [ACT_W-1:0]      best_act;
    logic signed [W_Q-1:0] q_tab [N_ENT];

    logic [IDX_W-1:0]      row_base, ent_idx, rd_idx, wr_idx;
    logic signed [W_Q-1:0] q_rd, alu_q, wr_data, exec_val, nbest_val;
    logic [ACT_W-1:0]      nbest_act;
    logic                  op_legal, need_act, cmd_err, is_wr, better, tab_we;
    logic                  unused_bits;

    function automatic logic [W_MSG-1:0] make_rsp(input logic [OP_W-1:0] op,
                                                  input logic [ST_W-1:0] st,
                                                  input logic [ACT_W-1:0] act,
                                                  input logic err,
                                                  input logic [W_Q-1:0] val);
        logic [W_MSG-1:0] r;
        r = '0;
        r[OP_LSB +: OP_W]   = op;
        r[ST_LSB +: ST_W]   = st;
        r[ACT_LSB +: ACT_W] = act;
        r[ERR_BIT]          = err;
        r[VAL_LSB +: W_Q]   = val;
        return r;
    endfunction

    assign unused_bits = ^in_msg[SH_LSB-1:VAL_LSB+W_Q];
    assign row_base    = IDX_W'(st_r) * IDX_W'(N_ACTIONS);
    assign ent_idx     = row_base + IDX_W'(act_r);
    assign rd_idx      = (state == S_SCAN) ? row_base + idx : ent_idx;
    assign q_rd        = q_tab[rd_idx];

    q_update_alu #(.W_Q(W_Q)) u_alu (
        .q     (q_rd),
        .v     (val_r),
        .sh    (sh_r[3:0]),
        .new_q (alu_q)
    );

    always_comb begin
        op_legal  = (op_r >= OP_WRITE) && (op_r <= OP_CLEAR);
        need_act  = (op_r == OP_WRITE) || (op_r == OP_READ) || (op_r == OP_UPDATE);
        cmd_err   = !op_legal
                  || ((op_r != OP_CLEAR) && (st_r >= ST_W'(N_STATES)))
                  || (need_act && (act_r >= ACT_W'(N_ACTIONS)))
                  || ((op_r == OP_UPDATE) && (sh_r > SH_W'(MAX_SH)));
        is_wr     = (op_r == OP_WRITE) || (op_r == OP_UPDATE);
        exec_val  = (op_r == OP_READ) ? q_rd : ((op_r == OP_WRITE) ? val_r : alu_q);
        // Strict compare keeps the lowest index on ties; entry 0 always seeds the scan.
        better    = (idx == '0) || (q_rd > best_val);
        nbest_val = better ? q_rd : best_val;
        nbest_act = better ? ACT_W'(idx) : best_act;
        tab_we    = !rst && (((state == S_EXEC) && is_wr && !cmd_err) || (state == S_CLR));
        wr_idx    = (state == S_CLR) ? idx : ent_idx;
        wr_data   = (state == S_CLR) ? '0 : exec_val;
    end

    always_ff @(posedge clk) begin
        if (tab_we) q_tab[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_msg_rdy) begin
            op_r  <= in_msg[OP_LSB +: OP_W];
            st_r  <= in_msg[ST_LSB +: ST_W];
            act_r <= in_msg[ACT_LSB +: ACT_W];
            sh_r  <= in_msg[SH_LSB +: SH_W];
            val_r <= in_msg[VAL_LSB +: W_Q];
        end
        if (state == S_SCAN) begin
            best_val <= nbest_val;
            best_act <= nbest_act;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            in_msg_ack  <= 1'b0;
            out_msg_rdy <= 1'b0;
            out_msg     <= '0;
            busy        <= 1'b0;
        end else begin
            in_msg_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_msg_rdy) begin
                        in_msg_ack <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    idx <= '0;
                    if (cmd_err) begin
                        out_msg     <= make_rsp(op_r, st_r, act_r, 1'b1, '0);
                        out_msg_rdy <= 1'b1;
                        state       <= S_RESP;
                    end else if (op_r == OP_ARGMAX) begin
                        state <= S_SCAN;
                    end else if (op_r == OP_CLEAR) begin
                        state <= S_CLR;
                    end else begin
                        out_msg     <= make_rsp(op_r, st_r, act_r, 1'b0, exec_val);
                        out_msg_rdy <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_SCAN: begin
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N_ACTIONS - 1)) begin
                        out_msg     <= make_rsp(op_r, st_r, nbest_act, 1'b0, nbest_val);
                        out_msg_rdy <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_CLR: begin
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N_ENT - 1)) begin
                        out_msg     <= make_rsp(op_r, st_r, act_r, 1'b0, '0);
                        out_msg_rdy <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (out_msg_ack) begin
                        out_msg_rdy <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_table_engine.sv
// Bench for q_table_engine: table of command/response vectors checked through a scoreboard,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_q_table_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_msg_rdy = 1'b0;
    logic [63:0] in_msg = '0;
    logic        in_msg_ack;
    logic        out_msg_rdy;
    logic [63:0] out_msg;
    logic        out_msg_ack = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    q_table_engine dut (
        .clk         (clk),
        .rst         (rst),
        .in_msg_rdy  (in_msg_rdy),
        .in_msg      (in_msg),
        .in_msg_ack  (in_msg_ack),
        .out_msg_rdy (out_msg_rdy),
        .out_msg     (out_msg),
        .out_msg_ack (out_msg_ack),
        .busy        (busy)
    );

    typedef struct {
        string       name;
        logic [63:0] cmd;
        logic [63:0] rsp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    int          n_chk = 0;
    int          n_err = 0;

    function automatic logic [63:0] mk_cmd(int op, int st, int act, int sh, int val);
        logic [63:0] c;
        c = '0;
        c[63:60] = 4'(op);
        c[59:48] = 12'(st);
        c[47:40] = 8'(act);
        c[39:32] = 8'(sh);
        c[15:0]  = 16'(val);
        return c;
    endfunction

    function automatic logic [63:0] mk_rsp(int op, int st, int act, int err, int val);
        logic [63:0] r;
        r = '0;
        r[63:60] = 4'(op);
        r[59:48] = 12'(st);
        r[47:40] = 8'(act);
        r[32]    = 1'(err);
        r[15:0]  = 16'(val);
        return r;
    endfunction

    function automatic void add(string n, logic [63:0] c, logic [63:0] r, int l);
        vec_t v;
        v.name = n;
        v.cmd  = c;
        v.rsp  = r;
        v.lat  = l;
        vecs.push_back(v);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [63:0] cmd, input logic [63:0] exp, input bit push);
        if (push) sb.push_back(exp);
        in_msg     = cmd;
        in_msg_rdy = 1'b1;
    endtask

    task automatic wait_rsp(input string name, input int exp_lat);
        int          cnt = 0;
        int          acks = 0;
        bit          busy_ok = 1'b1;
        bit          got = 1'b0;
        logic [63:0] exp;
        while (cnt < 300 && !got) begin
            @(posedge clk);
            #1;
            cnt++;
            if (in_msg_ack) begin
                acks++;
                in_msg_rdy = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (out_msg_rdy) got = 1'b1;
        end
        check_int({name, " ack pulses"}, acks, 1);
        check_int({name, " busy held"}, int'(busy_ok), 1);
        if (!got) begin
            n_chk++;
            n_err++;
            $display("FAIL %s timeout: no response after %0d cycles, expected one", name, cnt);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (exp_lat >= 0) check_int({name, " latency"}, cnt, exp_lat);
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: response with empty scoreboard, got %h", name, out_msg);
        end else begin
            exp = sb.pop_front();
            check64({name, " rsp"}, out_msg, exp);
        end
    endtask

    task automatic ack_rsp(input string name);
        out_msg_ack = 1'b1;
        @(posedge clk);
        #1;
        out_msg_ack = 1'b0;
        check_int({name, " rdy drop"}, int'(out_msg_rdy), 0);
        check_int({name, " busy drop"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] bp_exp;
        bit          stable, no_ack, no_rsp;

        add("write 3,1", mk_cmd(1, 3, 1, 0, 'h0100) | 64'h0000_0000_DEAD_0000, mk_rsp(1, 3, 1, 0, 'h0100), 2);
        add("read 3,1", mk_cmd(2, 3, 1, 0, 0), mk_rsp(2, 3, 1, 0, 'h0100), 2);
        add("update sh2", mk_cmd(3, 3, 1, 2, 'h0200), mk_rsp(3, 3, 1, 0, 'h0140), 2);
        add("write 5,2", mk_cmd(1, 5, 2, 0, 'h7FFF), mk_rsp(1, 5, 2, 0, 'h7FFF), 2);
        add("update extreme", mk_cmd(3, 5, 2, 0, 'h8000), mk_rsp(3, 5, 2, 0, 'h8000), 2);
        add("update up sh3", mk_cmd(3, 5, 2, 3, 'h0000), mk_rsp(3, 5, 2, 0, 'h9000), 2);
        add("update down sh4", mk_cmd(3, 5, 2, 4, 'h8000), mk_rsp(3, 5, 2, 0, 'h8F00), 2);
        add("update sh15", mk_cmd(3, 5, 2, 15, 'h7FFF), mk_rsp(3, 5, 2, 0, 'h8F01), 2);
        add("write 3,0", mk_cmd(1, 3, 0, 0, 'h0005), mk_rsp(1, 3, 0, 0, 'h0005), 2);
        add("write 3,2", mk_cmd(1, 3, 2, 0, 'h0140), mk_rsp(1, 3, 2, 0, 'h0140), 2);
        add("write 3,3", mk_cmd(1, 3, 3, 0, 'hFFFF), mk_rsp(1, 3, 3, 0, 'hFFFF), 2);
        add("argmax 3", mk_cmd(4, 3, 0, 0, 0), mk_rsp(4, 3, 1, 0, 'h0140), 6);
        add("illegal op F", mk_cmd(15, 3, 1, 0, 'h1111), mk_rsp(15, 3, 1, 1, 0), 2);
        add("read after F", mk_cmd(2, 3, 1, 0, 0), mk_rsp(2, 3, 1, 0, 'h0140), 2);
        add("read s=16", mk_cmd(2, 16, 1, 0, 0), mk_rsp(2, 16, 1, 1, 0), 2);
        add("read after s16", mk_cmd(2, 3, 1, 0, 0), mk_rsp(2, 3, 1, 0, 'h0140), 2);
        add("update sh16", mk_cmd(3, 3, 1, 16, 0), mk_rsp(3, 3, 1, 1, 0), 2);
        add("read after sh16", mk_cmd(2, 3, 1, 0, 0), mk_rsp(2, 3, 1, 0, 'h0140), 2);
        add("illegal op 0", mk_cmd(0, 3, 1, 0, 'h0022), mk_rsp(0, 3, 1, 1, 0), 2);
        add("write 4,0", mk_cmd(1, 4, 0, 0, 'h0042), mk_rsp(1, 4, 0, 0, 'h0042), 2);
        add("write a=4", mk_cmd(1, 3, 4, 0, 'h0007), mk_rsp(1, 3, 4, 1, 0), 2);
        add("read a=4", mk_cmd(2, 3, 4, 0, 0), mk_rsp(2, 3, 4, 1, 0), 2);
        add("read 4,0 intact", mk_cmd(2, 4, 0, 0, 0), mk_rsp(2, 4, 0, 0, 'h0042), 2);
        add("write 7,0", mk_cmd(1, 7, 0, 0, 'hFFFB), mk_rsp(1, 7, 0, 0, 'hFFFB), 2);
        add("write 7,1", mk_cmd(1, 7, 1, 0, 'hFFFD), mk_rsp(1, 7, 1, 0, 'hFFFD), 2);
        add("write 7,2", mk_cmd(1, 7, 2, 0, 'hFFFD), mk_rsp(1, 7, 2, 0, 'hFFFD), 2);
        add("write 7,3", mk_cmd(1, 7, 3, 0, 'hFFF7), mk_rsp(1, 7, 3, 0, 'hFFF7), 2);
        add("argmax 7 neg", mk_cmd(4, 7, 3, 0, 0), mk_rsp(4, 7, 1, 0, 'hFFFD), 6);
        add("argmax s=16", mk_cmd(4, 16, 0, 0, 0), mk_rsp(4, 16, 0, 1, 0), 2);
        add("clear", mk_cmd(5, 20, 2, 0, 'h5555), mk_rsp(5, 20, 2, 0, 0), 66);
        add("read 15,3 clr", mk_cmd(2, 15, 3, 0, 0), mk_rsp(2, 15, 3, 0, 0), 2);
        add("read 3,1 clr", mk_cmd(2, 3, 1, 0, 0), mk_rsp(2, 3, 1, 0, 0), 2);
        add("read 5,2 clr", mk_cmd(2, 5, 2, 0, 0), mk_rsp(2, 5, 2, 0, 0), 2);
        add("read 7,1 clr", mk_cmd(2, 7, 1, 0, 0), mk_rsp(2, 7, 1, 0, 0), 2);

        repeat (3) @(posedge clk);
        #1;
        check_int("reset in_msg_ack", int'(in_msg_ack), 0);
        check_int("reset out_msg_rdy", int'(out_msg_rdy), 0);
        check64("reset out_msg", out_msg, 64'h0);
        check_int("reset busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i].cmd, vecs[i].rsp, 1'b1);
            wait_rsp(vecs[i].name, vecs[i].lat);
            ack_rsp(vecs[i].name);
        end

        // Backpressure: response held unacked while the next command waits.
        bp_exp = mk_rsp(1, 9, 0, 0, 'h1234);
        issue(mk_cmd(1, 9, 0, 0, 'h1234), bp_exp, 1'b1);
        wait_rsp("bp write", 2);
        issue(mk_cmd(2, 9, 0, 0, 0), mk_rsp(2, 9, 0, 0, 'h1234), 1'b1);
        stable = 1'b1;
        no_ack = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_msg_rdy || out_msg !== bp_exp) stable = 1'b0;
            if (in_msg_ack) no_ack = 1'b0;
        end
        check_int("bp rsp stable", int'(stable), 1);
        check_int("bp no accept", int'(no_ack), 1);
        ack_rsp("bp write");
        wait_rsp("bp queued read", 2);
        ack_rsp("bp queued read");

        // Reset during an ARGMAX scan: the op is dropped without a response.
        issue(mk_cmd(4, 9, 0, 0, 0), 64'h0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (in_msg_ack) in_msg_rdy = 1'b0;
        end
        check_int("mid-scan busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_int("mid rst in_msg_ack", int'(in_msg_ack), 0);
        check_int("mid rst out_msg_rdy", int'(out_msg_rdy), 0);
        check64("mid rst out_msg", out_msg, 64'h0);
        check_int("mid rst busy", int'(busy), 0);
        rst = 1'b0;
        no_rsp = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_msg_rdy || busy) no_rsp = 1'b0;
        end
        check_int("no rsp after rst", int'(no_rsp), 1);

        issue(mk_cmd(2, 9, 0, 0, 0), mk_rsp(2, 9, 0, 0, 'h1234), 1'b1);
        wait_rsp("read after rst", 2);
        ack_rsp("read after rst");
        check_int("scoreboard empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
